// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point R2SDF FFT pipeline.
// Holds the word widths, the W8 twiddle constants and the 16-bit saturation helper.
package fft_pkg;
    localparam int STAGE3_IN_W  = 15;
    localparam int STAGE3_OUT_W = 16;
    localparam int TW_W         = 8;
    localparam int TW_FRAC      = 6;
    localparam int PROD_W       = STAGE3_OUT_W + TW_W + 1;

    typedef logic signed [TW_W-1:0]         tw_t;
    typedef logic signed [STAGE3_OUT_W-1:0] s16_t;
    typedef logic signed [PROD_W-1:0]       prod_t;

    // W8^k in Q1.6; W0 and W2 are applied exactly in the datapath.
    localparam tw_t W0_RE = 8'sd64;
    localparam tw_t W0_IM = 8'sd0;
    localparam tw_t W1_RE = 8'sd45;
    localparam tw_t W1_IM = -8'sd45;
    localparam tw_t W2_RE = 8'sd0;
    localparam tw_t W2_IM = -8'sd64;
    localparam tw_t W3_RE = -8'sd45;
    localparam tw_t W3_IM = -8'sd45;

    localparam prod_t SAT_MAX = 25'sd32767;
    localparam prod_t SAT_MIN = -25'sd32768;

    function automatic tw_t tw_re(input logic [1:0] k);
        case (k)
            2'd0:    return W0_RE;
            2'd1:    return W1_RE;
            2'd2:    return W2_RE;
            default: return W3_RE;
        endcase
    endfunction

    function automatic tw_t tw_im(input logic [1:0] k);
        case (k)
            2'd0:    return W0_IM;
            2'd1:    return W1_IM;
            2'd2:    return W2_IM;
            default: return W3_IM;
        endcase
    endfunction

    function automatic s16_t sat16(input prod_t v);
        if (v > SAT_MAX) begin
            return 16'sh7fff;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction
endpackage

// File: rtl/sr4.sv
// Four-entry complex 16-bit shift register used as the stage-3 feedback buffer.
// Entry 0 takes the pushed word; the head (entry 3) is the oldest word.
module sr4
    import fft_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           shift,
    input  logic signed [STAGE3_OUT_W-1:0] din_r,
    input  logic signed [STAGE3_OUT_W-1:0] din_i,
    output logic signed [STAGE3_OUT_W-1:0] head_r,
    output logic signed [STAGE3_OUT_W-1:0] head_i
);
    s16_t fb_r [4];
    s16_t fb_i [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                fb_r[n] <= '0;
                fb_i[n] <= '0;
            end
        end else if (shift) begin
            fb_r[0] <= din_r;
            fb_i[0] <= din_i;
            for (int n = 1; n < 4; n++) begin
                fb_r[n] <= fb_r[n-1];
                fb_i[n] <= fb_i[n-1];
            end
        end
    end

    assign head_r = fb_r[3];
    assign head_i = fb_i[3];
endmodule

// File: rtl/fft_stage3_r2sdf.sv
// Third R2SDF stage of the 32-point DIF FFT: 4-deep feedback, W8 twiddles, 15-bit in, 16-bit out.
// Pipeline: input register, combinational butterfly/rotation, output register (two-cycle latency).
module fft_stage3_r2sdf
    import fft_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_i,
    input  logic signed [STAGE3_IN_W-1:0]  data_in_r,
    input  logic signed [STAGE3_IN_W-1:0]  data_in_i,
    output logic                           valid_o,
    output logic signed [STAGE3_OUT_W-1:0] data_out_r,
    output logic signed [STAGE3_OUT_W-1:0] data_out_i
);
    logic                          in_v;
    logic signed [STAGE3_IN_W-1:0] in_r;
    logic signed [STAGE3_IN_W-1:0] in_i;
    logic [2:0]                    cnt;
    logic                          primed;
    logic                          bfly;
    logic [1:0]                    k;
    logic                          out_v;

    s16_t  head_r, head_i;
    s16_t  ext_r, ext_i;
    s16_t  sum_r, sum_i;
    s16_t  diff_r, diff_i;
    s16_t  rot_r, rot_i;
    s16_t  push_r, push_i;
    s16_t  res_r, res_i;
    prod_t ar, ai, cr, ci;
    prod_t mul_r, mul_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_v <= 1'b0;
            in_r <= '0;
            in_i <= '0;
        end else begin
            in_v <= valid_i;
            if (valid_i) begin
                in_r <= data_in_r;
                in_i <= data_in_i;
            end
        end
    end

    // cnt[2] selects FILL (0) or BFLY (1); both only move on an accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (in_v) begin
            cnt <= cnt + 3'd1;
            if (bfly) begin
                primed <= 1'b1;
            end
        end
    end

    assign bfly = cnt[2];
    assign k    = cnt[1:0];

    sr4 u_fb (
        .clk    (clk),
        .rst    (rst),
        .shift  (in_v),
        .din_r  (push_r),
        .din_i  (push_i),
        .head_r (head_r),
        .head_i (head_i)
    );

    always_comb begin
        ext_r  = s16_t'(in_r);
        ext_i  = s16_t'(in_i);
        sum_r  = head_r + ext_r;
        sum_i  = head_i + ext_i;
        diff_r = head_r - ext_r;
        diff_i = head_i - ext_i;

        ar    = prod_t'(head_r);
        ai    = prod_t'(head_i);
        cr    = prod_t'(tw_re(k));
        ci    = prod_t'(tw_im(k));
        mul_r = (ar * cr - ai * ci) >>> TW_FRAC;
        mul_i = (ar * ci + ai * cr) >>> TW_FRAC;

        rot_r = head_r;
        rot_i = head_i;
        case (k)
            2'd0: begin
                rot_r = head_r;
                rot_i = head_i;
            end
            2'd2: begin
                rot_r = head_i;
                rot_i = sat16(-ar);
            end
            default: begin
                rot_r = sat16(mul_r);
                rot_i = sat16(mul_i);
            end
        endcase

        push_r = bfly ? diff_r : ext_r;
        push_i = bfly ? diff_i : ext_i;
        res_r  = bfly ? sum_r : rot_r;
        res_i  = bfly ? sum_i : rot_i;
        // Before the first BFLY the buffer holds no real differences.
        out_v  = in_v & (bfly | primed);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
        end else begin
            valid_o <= out_v;
            if (out_v) begin
                data_out_r <= res_r;
                data_out_i <= res_i;
            end
        end
    end
endmodule

// File: tb/tb_fft_stage3_r2sdf.sv
// Self-checking bench for fft_stage3_r2sdf: frame-level reference model plus directed scenarios.
module tb_fft_stage3_r2sdf;
    logic               clk = 1'b0;
    logic               rst;
    logic               valid_i;
    logic signed [14:0] data_in_r;
    logic signed [14:0] data_in_i;
    logic               valid_o;
    logic signed [15:0] data_out_r;
    logic signed [15:0] data_out_i;

    always #5 clk = ~clk;

    fft_stage3_r2sdf dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i)
    );

    typedef struct {
        bit r;
        bit v;
        int xr;
        int xi;
    } stim_t;

    int checks = 0;
    int failures = 0;
    int step_no = 0;

    logic [32:0]        exp_q[$];
    logic               got_v, exp_v;
    logic signed [15:0] got_r, got_i, exp_r, exp_i;
    logic signed [15:0] obs_r[$];
    logic signed [15:0] obs_i[$];
    int                 obs_step[$];
    stim_t              stim_q[$];

    // Reference model: one frame of inputs, last frame's differences, sample index.
    int m_xr[8], m_xi[8], m_dr[4], m_di[4];
    int m_n;
    bit m_primed;
    logic signed [15:0] last_r, last_i;

    int ramp_r[8] = '{6, 8, 10, 12, -4, -3, 0, 2};
    int ramp_i[8] = '{0, 0, 0, 0, 0, 2, 4, 2};

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic rotate(input int a, input int b, input int k, output int re, output int im);
        int c, d;
        if (k == 0) begin
            re = a;
            im = b;
        end else if (k == 2) begin
            re = b;
            im = -a;
        end else begin
            c  = (k == 1) ? 45 : -45;
            d  = -45;
            re = (a * c - b * d) >>> 6;
            im = (a * d + b * c) >>> 6;
        end
        re = sat(re);
        im = sat(im);
    endtask

    task automatic model_reset();
        m_n = 0;
        m_primed = 1'b0;
        for (int j = 0; j < 8; j++) begin
            m_xr[j] = 0;
            m_xi[j] = 0;
        end
        for (int j = 0; j < 4; j++) begin
            m_dr[j] = 0;
            m_di[j] = 0;
        end
    endtask

    task automatic model_accept(input int xr, input int xi, output bit ov, output int orr, output int oi);
        int kk;
        ov = 1'b0;
        orr = 0;
        oi = 0;
        m_xr[m_n] = xr;
        m_xi[m_n] = xi;
        if (m_n >= 4) begin
            kk = m_n - 4;
            orr = m_xr[kk] + xr;
            oi = m_xi[kk] + xi;
            m_dr[kk] = m_xr[kk] - xr;
            m_di[kk] = m_xi[kk] - xi;
            m_primed = 1'b1;
            ov = 1'b1;
        end else if (m_primed) begin
            rotate(m_dr[m_n], m_di[m_n], m_n, orr, oi);
            ov = 1'b1;
        end
        m_n = (m_n + 1) % 8;
    endtask

    // One clock: sample the outputs due now, advance the model, drive the next inputs.
    task automatic step(input bit r_in, input bit v, input int xr, input int xi);
        logic [32:0] e;
        bit ov;
        int orr, oi;
        @(negedge clk);
        step_no++;
        got_v = valid_o;
        got_r = data_out_r;
        got_i = data_out_i;
        e = exp_q.pop_front();
        exp_v = e[32];
        exp_r = e[31:16];
        exp_i = e[15:0];
        if (got_v === 1'b1) begin
            obs_r.push_back(got_r);
            obs_i.push_back(got_i);
            obs_step.push_back(step_no);
        end
        if (r_in) begin
            model_reset();
            last_r = '0;
            last_i = '0;
            exp_q[0] = '0;
            exp_q.push_back('0);
        end else begin
            ov = 1'b0;
            orr = 0;
            oi = 0;
            if (v) model_accept(xr, xi, ov, orr, oi);
            if (ov) begin
                last_r = 16'(orr);
                last_i = 16'(oi);
            end
            exp_q.push_back({ov, last_r, last_i});
        end
        rst = r_in;
        valid_i = v;
        data_in_r = 15'(xr);
        data_in_i = 15'(xi);
    endtask

    task automatic add(input bit r, input bit v, input int xr, input int xi);
        stim_t s;
        s.r = r;
        s.v = v;
        s.xr = xr;
        s.xi = xi;
        stim_q.push_back(s);
    endtask

    task automatic clear_obs();
        obs_r.delete();
        obs_i.delete();
        obs_step.delete();
    endtask

    task automatic test_reset();
        for (int j = 0; j < 6; j++) begin
            step(j < 3, 1'b1, int'($urandom_range(0, 32767)) - 16384, 100);
            checks++;
            if (got_v !== 1'b0 || got_r !== 16'sd0 || got_i !== 16'sd0) begin
                failures++;
                $display("FAIL reset step=%0d got v=%0b (%0d,%0d) exp v=0 (0,0)", step_no, got_v, got_r, got_i);
            end
        end
        step(1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_ramp();
        int start;
        stim_q.delete();
        add(1, 0, 0, 0);
        for (int n = 0; n < 8; n++) add(0, 1, n + 1, 0);
        for (int n = 0; n < 4; n++) add(0, 1, 0, 0);
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        start = step_no + 1;
        foreach (stim_q[j]) begin
            step(stim_q[j].r, stim_q[j].v, stim_q[j].xr, stim_q[j].xi);
            if (j == 0) clear_obs();
            checks++;
            if (got_v !== exp_v || got_r !== exp_r || got_i !== exp_i) begin
                failures++;
                $display("FAIL ramp step=%0d got v=%0b (%0d,%0d) exp v=%0b (%0d,%0d)", step_no, got_v, got_r, got_i, exp_v, exp_r, exp_i);
            end
        end
        checks++;
        if (obs_r.size() != 8) begin
            failures++;
            $display("FAIL ramp_count got %0d exp 8", obs_r.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (obs_r[j] !== 16'(ramp_r[j]) || obs_i[j] !== 16'(ramp_i[j])) begin
                    failures++;
                    $display("FAIL ramp_value[%0d] got (%0d,%0d) exp (%0d,%0d)", j, obs_r[j], obs_i[j], ramp_r[j], ramp_i[j]);
                end
            end
            checks++;
            if (obs_step[0] != start + 7) begin
                failures++;
                $display("FAIL ramp_first_valid got step %0d exp %0d", obs_step[0], start + 7);
            end
        end
    endtask

    task automatic test_back_to_back();
        int start, idx;
        stim_q.delete();
        add(1, 0, 0, 0);
        for (int f = 0; f < 4; f++)
            for (int n = 0; n < 8; n++) add(0, 1, n + 1, 0);
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        start = step_no + 1;
        foreach (stim_q[j]) begin
            step(stim_q[j].r, stim_q[j].v, stim_q[j].xr, stim_q[j].xi);
            if (j == 0) clear_obs();
            checks++;
            if (got_v !== exp_v || got_r !== exp_r || got_i !== exp_i) begin
                failures++;
                $display("FAIL b2b step=%0d got v=%0b (%0d,%0d) exp v=%0b (%0d,%0d)", step_no, got_v, got_r, got_i, exp_v, exp_r, exp_i);
            end
        end
        checks++;
        if (obs_r.size() != 28) begin
            failures++;
            $display("FAIL b2b_count got %0d exp 28", obs_r.size());
        end else begin
            for (int j = 0; j < 28; j++) begin
                idx = ((j / 4) % 2 == 1) ? 4 + (j % 4) : (j % 4);
                checks++;
                if (obs_r[j] !== 16'(ramp_r[idx]) || obs_i[j] !== 16'(ramp_i[idx])) begin
                    failures++;
                    $display("FAIL b2b_value[%0d] got (%0d,%0d) exp (%0d,%0d)", j, obs_r[j], obs_i[j], ramp_r[idx], ramp_i[idx]);
                end
            end
            checks++;
            if (obs_step[0] != start + 7 || obs_step[27] - obs_step[0] != 27) begin
                failures++;
                $display("FAIL b2b_timing got first=%0d last=%0d exp first=%0d last=%0d", obs_step[0], obs_step[27], start + 7, start + 34);
            end
        end
    endtask

    task automatic test_bubbles();
        int start, bad;
        stim_q.delete();
        add(1, 0, 0, 0);
        for (int n = 0; n < 12; n++) begin
            add(0, 1, (n < 8) ? n + 1 : 0, 0);
            add(0, 0, 999, -999);
            add(0, 0, -7, 7);
        end
        start = step_no + 1;
        foreach (stim_q[j]) begin
            step(stim_q[j].r, stim_q[j].v, stim_q[j].xr, stim_q[j].xi);
            if (j == 0) clear_obs();
            checks++;
            if (got_v !== exp_v || got_r !== exp_r || got_i !== exp_i) begin
                failures++;
                $display("FAIL bubbles step=%0d got v=%0b (%0d,%0d) exp v=%0b (%0d,%0d)", step_no, got_v, got_r, got_i, exp_v, exp_r, exp_i);
            end
        end
        checks++;
        if (obs_r.size() != 8) begin
            failures++;
            $display("FAIL bubbles_count got %0d exp 8", obs_r.size());
        end else begin
            bad = 0;
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (obs_r[j] !== 16'(ramp_r[j]) || obs_i[j] !== 16'(ramp_i[j])) begin
                    failures++;
                    $display("FAIL bubbles_value[%0d] got (%0d,%0d) exp (%0d,%0d)", j, obs_r[j], obs_i[j], ramp_r[j], ramp_i[j]);
                end
                if (j > 0 && obs_step[j] - obs_step[j-1] != 3) bad++;
            end
            checks++;
            if (obs_step[0] != start + 15 || bad != 0) begin
                failures++;
                $display("FAIL bubbles_timing got first=%0d bad_gaps=%0d exp first=%0d bad_gaps=0", obs_step[0], bad, start + 15);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int start;
        stim_q.delete();
        add(1, 0, 0, 0);
        for (int n = 0; n < 6; n++) add(0, 1, n + 1, 0);
        add(1, 1, 777, -5);
        for (int n = 0; n < 8; n++) add(0, 1, n + 1, 0);
        for (int n = 0; n < 4; n++) add(0, 1, 0, 0);
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        start = 0;
        foreach (stim_q[j]) begin
            step(stim_q[j].r, stim_q[j].v, stim_q[j].xr, stim_q[j].xi);
            if (j == 0 || j == 7) begin
                clear_obs();
                start = step_no + 1;
            end
            checks++;
            if (got_v !== exp_v || got_r !== exp_r || got_i !== exp_i) begin
                failures++;
                $display("FAIL reset_mid step=%0d got v=%0b (%0d,%0d) exp v=%0b (%0d,%0d)", step_no, got_v, got_r, got_i, exp_v, exp_r, exp_i);
            end
        end
        checks++;
        if (obs_r.size() != 8) begin
            failures++;
            $display("FAIL reset_mid_count got %0d exp 8", obs_r.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (obs_r[j] !== 16'(ramp_r[j]) || obs_i[j] !== 16'(ramp_i[j])) begin
                    failures++;
                    $display("FAIL reset_mid_value[%0d] got (%0d,%0d) exp (%0d,%0d)", j, obs_r[j], obs_i[j], ramp_r[j], ramp_i[j]);
                end
            end
            checks++;
            if (obs_step[0] != start + 6) begin
                failures++;
                $display("FAIL reset_mid_priming got step %0d exp %0d", obs_step[0], start + 6);
            end
        end
    endtask

    task automatic test_saturation();
        stim_q.delete();
        add(1, 0, 0, 0);
        for (int n = 0; n < 12; n++) begin
            if (n == 1) add(0, 1, 16383, 16383);
            else if (n == 5) add(0, 1, -16384, -16384);
            else add(0, 1, 0, 0);
        end
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        foreach (stim_q[j]) begin
            step(stim_q[j].r, stim_q[j].v, stim_q[j].xr, stim_q[j].xi);
            if (j == 0) clear_obs();
            checks++;
            if (got_v !== exp_v || got_r !== exp_r || got_i !== exp_i) begin
                failures++;
                $display("FAIL sat step=%0d got v=%0b (%0d,%0d) exp v=%0b (%0d,%0d)", step_no, got_v, got_r, got_i, exp_v, exp_r, exp_i);
            end
        end
        checks++;
        if (obs_r.size() != 8) begin
            failures++;
            $display("FAIL sat_count got %0d exp 8", obs_r.size());
        end else begin
            checks++;
            if (obs_r[1] !== -16'sd1 || obs_i[1] !== -16'sd1) begin
                failures++;
                $display("FAIL sat_s1 got (%0d,%0d) exp (-1,-1)", obs_r[1], obs_i[1]);
            end
            checks++;
            if (obs_r[5] !== 16'sd32767 || obs_i[5] !== 16'sd0) begin
                failures++;
                $display("FAIL sat_z1 got (%0d,%0d) exp (32767,0)", obs_r[5], obs_i[5]);
            end
        end
    endtask

    task automatic test_neg_full_scale();
        stim_q.delete();
        add(1, 0, 0, 0);
        for (int n = 0; n < 12; n++) begin
            if (n == 2) add(0, 1, -16384, -16384);
            else if (n == 6) add(0, 1, 16383, 16383);
            else add(0, 1, 0, 0);
        end
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        foreach (stim_q[j]) begin
            step(stim_q[j].r, stim_q[j].v, stim_q[j].xr, stim_q[j].xi);
            if (j == 0) clear_obs();
            checks++;
            if (got_v !== exp_v || got_r !== exp_r || got_i !== exp_i) begin
                failures++;
                $display("FAIL negfs step=%0d got v=%0b (%0d,%0d) exp v=%0b (%0d,%0d)", step_no, got_v, got_r, got_i, exp_v, exp_r, exp_i);
            end
        end
        checks++;
        if (obs_r.size() != 8) begin
            failures++;
            $display("FAIL negfs_count got %0d exp 8", obs_r.size());
        end else begin
            checks++;
            if (obs_r[6] !== -16'sd32767 || obs_i[6] !== 16'sd32767) begin
                failures++;
                $display("FAIL negfs_z2 got (%0d,%0d) exp (-32767,32767)", obs_r[6], obs_i[6]);
            end
        end
    endtask

    task automatic test_random();
        int sel, xr, xi;
        bit r, v;
        for (int j = 0; j < 400; j++) begin
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 75);
            sel = $urandom_range(0, 3);
            xr = (sel == 0) ? -16384 : (sel == 1) ? 16383 : int'($urandom_range(0, 32767)) - 16384;
            sel = $urandom_range(0, 3);
            xi = (sel == 0) ? -16384 : (sel == 1) ? 16383 : int'($urandom_range(0, 32767)) - 16384;
            step(r, v, xr, xi);
            checks++;
            if (got_v !== exp_v || got_r !== exp_r || got_i !== exp_i) begin
                failures++;
                $display("FAIL random step=%0d got v=%0b (%0d,%0d) exp v=%0b (%0d,%0d)", step_no, got_v, got_r, got_i, exp_v, exp_r, exp_i);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0;
        data_in_r = '0;
        data_in_i = '0;
        last_r = '0;
        last_i = '0;
        model_reset();
        exp_q.push_back('0);
        exp_q.push_back('0);
        repeat (3) @(negedge clk);

        test_reset();
        test_ramp();
        test_back_to_back();
        test_bubbles();
        test_reset_mid_frame();
        test_saturation();
        test_neg_full_scale();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
